fp_add_align: RTL and testbench
===============================

Name: fp_add_align

Overview:
Front-end stage of the single-precision FP add/sub pipeline, ahead of the normalization stage. It accepts two IEEE-754 binary32 operands and:
- unpacks them and restores the hidden bit;
- applies FSUB sign inversion;
- orders them by magnitude;
- right-aligns the smaller mantissa with guard/round/sticky bits.
It is a 2-stage valid/ready pipeline feeding the mantissa adder and normalizer.

Parameters:
MANT_W, 23, stored fraction width
EXP_W, 8, exponent width
GRS_W, 3, extra guard/round/sticky bits appended below the mantissa

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
op_a  input  32  operand A, binary32
op_b  input  32  operand B, binary32
op_sub  input  1  1 = A-B (invert sign of B), 0 = A+B
out_valid  output  1  aligned result valid
out_ready  input  1  downstream accepts result
exp_large_out  output  8  effective exponent of larger-magnitude operand
sign_large  output  1  sign of larger operand (after op_sub)
eff_sub  output  1  effective subtraction = sign_a ^ sign_b_eff
mant_large  output  27  {hidden, fraction, 3'b000}
mant_small_aligned  output  27  smaller mantissa shifted right, LSB = sticky
is_nan  output  1  special flag (see Optional Feature)
is_inf  output  1  special flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - both stage valids, out_valid and all data outputs → 0.
  - in_ready → 1 in the first cycle after release.
  - Reset mid-operation discards all in-flight pairs.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - Outputs hold stable while out_valid & !out_ready.
- Stage enables:
  - S2 loads when !s2_valid | out_ready.
  - S1 loads when !s1_valid | s2 load.
  - in_ready = !s1_valid | s2 load (combinational from out_ready allowed).
- Latency and throughput:
  - Latency 2 cycles: a pair accepted at edge N is presented with out_valid at edge N+2.
  - Full throughput of 1 pair/cycle with out_ready held high.
- Stage 1 (unpack/compare):
  - sign_b_eff = op_b[31] ^ op_sub.
  - hidden = (exp != 0).
  - Effective exponent = 1 when the stored exponent is 0 (denormal).
  - Magnitude compare on {eff_exp, hidden, fraction}. A ≥ B selects A as large; on a tie A is large.
  - diff = eff_exp_large − eff_exp_small, 8-bit unsigned, never negative.
  - Register the large/small mantissas (24b), exp_large, sign_large, eff_sub and diff.
- Stage 2 (align):
  - small27 = {mant_small, 3'b000}, shifted right by diff.
  - sticky = OR of all bits shifted out, ORed into bit 0.
  - diff ≥ 27: mant_small_aligned = {26'b0, |mant_small}.
  - mant_large passes unshifted with 3 zero bits appended.
  - exp_large_out is the effective exponent of the large operand.
- Zero operands align as ordinary values (mantissa 0, sticky 0).
- Simultaneous input accept and output consume in one cycle: both occur, no bubble.

Optional Feature:
Macro FP_ALIGN_SPECIAL_EN.
- Defined: Stage 1 classifies operands; flags travel with the data and align to out_valid.
  - is_nan = either operand NaN, or (eff_sub and both operands ±Inf).
  - is_inf = either operand Inf and !is_nan.
- Undefined: is_nan and is_inf are tied to 0 and the classification logic is absent. Datapath is identical in both builds.

Test Plan:
- 0x3F800000 + 0x3F800000, op_sub=0 → exp_large_out 0x7F, mant_large 0x4000000, mant_small_aligned 0x4000000, eff_sub 0, out_valid exactly 2 cycles after accept.
- 0x3FC00000 + 0x3E800000 → diff 2, exp_large_out 0x7F, mant_large 0x6000000, mant_small_aligned 0x1000000.
- 0x4B800000 + 0x3F800001 → diff 24, mant_small_aligned 0x0000005 (sticky set from lost bit 3). 0x7F000000 + 0x00000001 → diff ≥ 27, aligned = 0x0000001.
- op_a=0x3E800000, op_b=0x3FC00000, op_sub=1 → B large, sign_large 1, eff_sub 1. With FP_ALIGN_SPECIAL_EN: 0x7F800000 − 0x7F800000 → is_nan 1. Without the macro: the same pair → is_nan 0.
- Stream 4 pairs with out_ready low for 3 cycles → in_ready drops after 2 accepted. On release, all 4 results emerge in order and unchanged; no drop or duplicate.
- Assert rst_n low while out_valid=1 → out_valid and outputs 0 immediately, no clock edge needed. After release, the first new pair returns in 2 cycles.

Source files
------------

// File: rtl/fp_add_align_if.sv
// ---------------------------------------------------------------------------
// fp_add_align_if
// Bundles the operand-side and result-side handshakes of the FP add/sub
// alignment front end into one interface.
//
// Signals:
//   in_valid, in_ready    operand-pair handshake
//   op_a, op_b            binary32 operands
//   op_sub                1 = A-B, 0 = A+B
//   out_valid, out_ready  aligned-result handshake
//   exp_large_out         effective exponent of the larger-magnitude operand
//   sign_large            sign of the larger operand (after op_sub)
//   eff_sub               effective subtraction flag
//   mant_large            {hidden, fraction, GRS zeros}
//   mant_small_aligned    right-aligned smaller mantissa, LSB = sticky
//   is_nan, is_inf        special-value flags (zero unless FP_ALIGN_SPECIAL_EN)
//
// Modports:
//   slave   the alignment block itself
//   master  the producer/consumer around it (testbench or pipeline glue)
// ---------------------------------------------------------------------------
interface fp_add_align_if #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int GRS_W  = 3
);
  localparam int OP_W = 1 + EXP_W + MANT_W;
  localparam int AL_W = MANT_W + 1 + GRS_W;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              op_sub;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_large_out;
  logic              sign_large;
  logic              eff_sub;
  logic [AL_W-1:0]   mant_large;
  logic [AL_W-1:0]   mant_small_aligned;
  logic              is_nan;
  logic              is_inf;

  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, exp_large_out, sign_large, eff_sub,
           mant_large, mant_small_aligned, is_nan, is_inf
  );

  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, exp_large_out, sign_large, eff_sub,
           mant_large, mant_small_aligned, is_nan, is_inf
  );
endinterface

// File: rtl/fp_add_align.sv
// ---------------------------------------------------------------------------
// fp_add_align
// Front end of the single-precision FP add/sub pipeline. Unpacks two binary32
// operands, restores hidden bits, applies the FSUB sign inversion, orders the
// operands by magnitude (stage 1) and right-aligns the smaller mantissa with
// guard/round/sticky bits (stage 2). Two-stage valid/ready pipeline, latency
// 2, one pair per cycle when the consumer keeps out_ready high.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every stage and all outputs
//   bus    fp_add_align_if.slave: operand handshake, result handshake and
//          aligned result fields (see the interface header)
//
// Configuration:
//   FP_ALIGN_SPECIAL_EN  when defined, stage 1 classifies NaN/Inf operands and
//                        the flags ride alongside the data; when undefined
//                        is_nan/is_inf are tied low. The datapath is the same
//                        in both builds.
// ---------------------------------------------------------------------------
module fp_add_align #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int GRS_W  = 3
) (
  input logic           clk,
  input logic           rst_n,
  fp_add_align_if.slave bus
);
  localparam int SIG_W = MANT_W + 1;
  localparam int AL_W  = SIG_W + GRS_W;
  localparam int OP_W  = 1 + EXP_W + MANT_W;

  // Pipeline control
  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;

  // Stage 1 unpack
  logic              sign_a, sign_b_eff;
  logic [EXP_W-1:0]  exp_a, exp_b, eexp_a, eexp_b;
  logic [MANT_W-1:0] frac_a, frac_b;
  logic              hid_a, hid_b;
  logic [SIG_W-1:0]  sig_a, sig_b;
  logic              a_large;
  logic              eff_sub_c;

  assign sign_a     = bus.op_a[OP_W-1];
  assign sign_b_eff = bus.op_b[OP_W-1] ^ bus.op_sub;
  assign exp_a      = bus.op_a[OP_W-2 -: EXP_W];
  assign exp_b      = bus.op_b[OP_W-2 -: EXP_W];
  assign frac_a     = bus.op_a[MANT_W-1:0];
  assign frac_b     = bus.op_b[MANT_W-1:0];
  assign hid_a      = |exp_a;
  assign hid_b      = |exp_b;
  // Denormals share the exponent of the smallest normal (1).
  assign eexp_a     = hid_a ? exp_a : EXP_W'(1);
  assign eexp_b     = hid_b ? exp_b : EXP_W'(1);
  assign sig_a      = {hid_a, frac_a};
  assign sig_b      = {hid_b, frac_b};
  // Ties go to A so the ordering is deterministic for equal magnitudes.
  assign a_large    = {eexp_a, sig_a} >= {eexp_b, sig_b};
  assign eff_sub_c  = sign_a ^ sign_b_eff;

  logic [SIG_W-1:0] s1_mant_large, s1_mant_small;
  logic [EXP_W-1:0] s1_exp_large, s1_diff;
  logic             s1_sign_large, s1_eff_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_mant_large <= '0;
      s1_mant_small <= '0;
      s1_exp_large  <= '0;
      s1_diff       <= '0;
      s1_sign_large <= 1'b0;
      s1_eff_sub    <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_eff_sub <= eff_sub_c;
        if (a_large) begin
          s1_mant_large <= sig_a;
          s1_mant_small <= sig_b;
          s1_exp_large  <= eexp_a;
          s1_diff       <= eexp_a - eexp_b;
          s1_sign_large <= sign_a;
        end else begin
          s1_mant_large <= sig_b;
          s1_mant_small <= sig_a;
          s1_exp_large  <= eexp_b;
          s1_diff       <= eexp_b - eexp_a;
          s1_sign_large <= sign_b_eff;
        end
      end
    end
  end

  // Stage 2 align: anything shifted past the LSB collapses into the sticky bit.
  logic [AL_W-1:0] small_ext, shifted, lost_mask, aligned;
  logic            sticky;

  always_comb begin
    small_ext = {s1_mant_small, GRS_W'(0)};
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    if (s1_diff >= EXP_W'(AL_W)) begin
      aligned = {{(AL_W-1){1'b0}}, |s1_mant_small};
    end else begin
      shifted   = small_ext >> s1_diff;
      lost_mask = ~({AL_W{1'b1}} << s1_diff);
      sticky    = |(small_ext & lost_mask);
      aligned   = {shifted[AL_W-1:1], shifted[0] | sticky};
    end
  end

  logic [EXP_W-1:0] out_exp;
  logic             out_sign, out_eff_sub;
  logic [AL_W-1:0]  out_mant_large, out_mant_small;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid       <= 1'b0;
      out_exp        <= '0;
      out_sign       <= 1'b0;
      out_eff_sub    <= 1'b0;
      out_mant_large <= '0;
      out_mant_small <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_exp        <= s1_exp_large;
        out_sign       <= s1_sign_large;
        out_eff_sub    <= s1_eff_sub;
        out_mant_large <= {s1_mant_large, GRS_W'(0)};
        out_mant_small <= aligned;
      end
    end
  end

`ifdef FP_ALIGN_SPECIAL_EN
  // Special-value classification, carried with the data through both stages.
  logic nan_a, nan_b, inf_a, inf_b, nan_c, inf_c;
  logic s1_is_nan, s1_is_inf, out_is_nan, out_is_inf;

  assign nan_a = (&exp_a) && (|frac_a);
  assign nan_b = (&exp_b) && (|frac_b);
  assign inf_a = (&exp_a) && !(|frac_a);
  assign inf_b = (&exp_b) && !(|frac_b);
  // Inf - Inf (after sign inversion) has no defined result.
  assign nan_c = nan_a || nan_b || (eff_sub_c && inf_a && inf_b);
  assign inf_c = (inf_a || inf_b) && !nan_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_is_nan  <= 1'b0;
      s1_is_inf  <= 1'b0;
      out_is_nan <= 1'b0;
      out_is_inf <= 1'b0;
    end else begin
      if (s1_load && bus.in_valid) begin
        s1_is_nan <= nan_c;
        s1_is_inf <= inf_c;
      end
      if (s2_load && s1_valid) begin
        out_is_nan <= s1_is_nan;
        out_is_inf <= s1_is_inf;
      end
    end
  end

  assign bus.is_nan = out_is_nan;
  assign bus.is_inf = out_is_inf;
`else
  assign bus.is_nan = 1'b0;
  assign bus.is_inf = 1'b0;
`endif

  assign bus.in_ready           = s1_load;
  assign bus.out_valid          = s2_valid;
  assign bus.exp_large_out      = out_exp;
  assign bus.sign_large         = out_sign;
  assign bus.eff_sub            = out_eff_sub;
  assign bus.mant_large         = out_mant_large;
  assign bus.mant_small_aligned = out_mant_small;
endmodule

// File: tb/tb_fp_add_align.sv
// ---------------------------------------------------------------------------
// tb_fp_add_align
// Directed, table-driven bench for fp_add_align: single transactions with
// latency checks, a back-pressured stream of four pairs, and an asynchronous
// reset while a result is held. Expected values are hand-computed; the NaN
// expectation follows FP_ALIGN_SPECIAL_EN.
// ---------------------------------------------------------------------------
module tb_fp_add_align;
  logic clk;
  logic rst_n;

  fp_add_align_if bus ();

  fp_add_align dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef FP_ALIGN_SPECIAL_EN
  localparam logic SP = 1'b1;
`else
  localparam logic SP = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [7:0]  exp;
    logic [26:0] ml;
    logic [26:0] ms;
    logic        sl;
    logic        es;
    logic        nan;
    logic        inf;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int assert_count = 0;
  int fail_count   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic sub,
                              logic [7:0] exp, logic [26:0] ml, logic [26:0] ms,
                              logic sl, logic es, logic nan, logic inf);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.exp = exp; v.ml = ml; v.ms = ms;
    v.sl = sl; v.es = es; v.nan = nan; v.inf = inf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input string tag, input int k);
    checkOutput($sformatf("%s_exp", tag), 32'(bus.exp_large_out), 32'(vecs[k].exp));
    checkOutput($sformatf("%s_ml", tag), 32'(bus.mant_large), 32'(vecs[k].ml));
    checkOutput($sformatf("%s_ms", tag), 32'(bus.mant_small_aligned), 32'(vecs[k].ms));
    checkOutput($sformatf("%s_sl", tag), 32'(bus.sign_large), 32'(vecs[k].sl));
    checkOutput($sformatf("%s_es", tag), 32'(bus.eff_sub), 32'(vecs[k].es));
    checkOutput($sformatf("%s_nan", tag), 32'(bus.is_nan), 32'(vecs[k].nan));
    checkOutput($sformatf("%s_inf", tag), 32'(bus.is_inf), 32'(vecs[k].inf));
  endtask

  // Presents one pair from an idle pipeline and waits (bounded) for accept.
  task automatic applyStimulus(input int k);
    int n;
    @(negedge clk);
    bus.op_a     = vecs[k].a;
    bus.op_b     = vecs[k].b;
    bus.op_sub   = vecs[k].sub;
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("v%0d_accept", k), 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput($sformatf("v%0d_lat1", k), 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput($sformatf("v%0d_lat2", k), 32'(bus.out_valid), 32'd1);
    checkVec($sformatf("v%0d", k), k);
  endtask

  initial begin
    int acc, recv, cyc;
    logic take;

    vecs[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(32'h3FC00000, 32'h3E800000, 1'b0, 8'h7F, 27'h6000000, 27'h1000000, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(32'h4B800000, 32'h3F800001, 1'b0, 8'h97, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(32'h7F000000, 32'h00000001, 1'b0, 8'hFE, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(32'h3E800000, 32'h3FC00000, 1'b1, 8'h7F, 27'h6000000, 27'h1000000, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(32'h7F800000, 32'h7F800000, 1'b1, 8'hFF, 27'h4000000, 27'h4000000, 1'b0, 1'b1, SP,   1'b0);
    vecs[6]  = mk(32'h00000000, 32'h80000000, 1'b0, 8'h01, 27'h0000000, 27'h0000000, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(32'h00000001, 32'h00000003, 1'b0, 8'h01, 27'h0000018, 27'h0000008, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(32'h7F800000, 32'h3F800000, 1'b0, 8'hFF, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, SP);
    vecs[9]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 8'hFF, 27'h6000000, 27'h0000001, 1'b0, 1'b0, SP,   1'b0);
    vecs[10] = mk(32'h3F800000, 32'h3D800001, 1'b0, 8'h7F, 27'h4000000, 27'h0400001, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(32'hBF800000, 32'h3F000000, 1'b0, 8'h7F, 27'h4000000, 27'h2000000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset state, checked before any clock edge has been seen.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mant_large", 32'(bus.mant_large), 32'd0);
    checkOutput("rst_exp", 32'(bus.exp_large_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] table-driven vectors");
    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(k);
    end
    @(negedge clk);
    checkOutput("drain_idle", 32'(bus.out_valid), 32'd0);

    $display("[TB] back-pressured stream of four pairs");
    acc  = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 4 && cyc < 40) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 3);
      if (acc < 4) begin
        bus.op_a     = vecs[acc].a;
        bus.op_b     = vecs[acc].b;
        bus.op_sub   = vecs[acc].sub;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("stall_accepted", 32'(acc), 32'd2);
        checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && !bus.out_ready) begin
        checkOutput($sformatf("hold%0d_ms", recv), 32'(bus.mant_small_aligned),
                    32'(vecs[recv].ms));
      end
      if (bus.out_valid && bus.out_ready) begin
        checkVec($sformatf("s%0d", recv), recv);
        recv++;
      end
      take = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (take) acc++;
      cyc++;
    end
    checkOutput("stream_received", 32'(recv), 32'd4);
    checkOutput("stream_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("stream_no_dup", 32'(bus.out_valid), 32'd0);

    $display("[TB] asynchronous reset while a result is held");
    bus.out_ready = 1'b0;
    bus.op_a      = vecs[1].a;
    bus.op_b      = vecs[1].b;
    bus.op_sub    = vecs[1].sub;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_rst_ml", 32'(bus.mant_large), 32'd0);
    checkOutput("async_rst_ms", 32'(bus.mant_small_aligned), 32'd0);
    checkOutput("async_rst_exp", 32'(bus.exp_large_out), 32'd0);
    checkOutput("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(2);
    @(negedge clk);
    checkOutput("final_idle", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
